// File: rtl/fix_logon_acceptor.sv
// FIX logon acceptor: parses an inbound tag=value;... byte stream, decides on
// ACK / REJ / LOGOUT at the "10=" checksum field and serialises the response.
module fix_logon_acceptor (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] din,
  input  logic       configure,
  input  logic [7:0] heartBeatInt,
  output logic [7:0] dout,
  output logic       valid,
  output logic       logged_on,
  output logic       busy,
  output logic [7:0] hb_int
);

  typedef enum logic [2:0] {IDLE, RX, TX_ACK, TX_REJ, TX_LOGOUT} state_e;
  typedef enum logic {P_TAG, P_VAL} pstate_e;

  localparam logic [7:0] CH_SEMI  = 8'h3b;
  localparam logic [7:0] CH_EQ    = 8'h3d;
  localparam logic [7:0] CH_A     = 8'h41;
  localparam logic [7:0] CH_5     = 8'h35;
  localparam logic [7:0] CH_3     = 8'h33;
  localparam logic [7:0] CH_0     = 8'h30;

  state_e      state_q, state_d;
  pstate_e     pstate_q, pstate_d;
  logic [9:0]  tag_q, tag_d;
  logic [7:0]  msgtype_q, msgtype_d;
  logic [7:0]  hb_rx_q, hb_rx_d;
  logic        fmt_err_q, fmt_err_d;
  logic        val_first_q, val_first_d;
  logic [7:0]  cfg_hb_q, cfg_hb_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  hb_tx_q, hb_tx_d;
  logic        logged_on_q, logged_on_d;
  logic [7:0]  hb_int_q, hb_int_d;

  logic        tx_active;
  logic        is_digit;
  logic        tx_last;
  logic [13:0] tag_mac;
  logic [11:0] hb_mac;
  state_e      resp;
  logic [7:0]  hund, tens, ones;

  assign tx_active = (state_q == TX_ACK) || (state_q == TX_REJ) || (state_q == TX_LOGOUT);
  assign is_digit  = (din >= 8'h30) && (din <= 8'h39);
  assign tag_mac   = {4'd0, tag_q} * 14'd10 + {10'd0, din[3:0]};
  assign hb_mac    = {4'd0, hb_rx_q} * 12'd10 + {8'd0, din[3:0]};
  assign tx_last   = (state_q == TX_ACK) ? (idx_q == 4'd12) : (idx_q == 4'd4);

  // Response choice is evaluated every cycle but only used on the end-of-message ';'.
  always_comb begin
    resp = IDLE;
    if (!logged_on_q) begin
      if (msgtype_q == CH_A && !fmt_err_q && hb_rx_q != 8'd0 && hb_rx_q <= cfg_hb_q)
        resp = TX_ACK;
      else
        resp = TX_REJ;
    end else if (msgtype_q == CH_A) begin
      resp = TX_REJ;
    end else if (msgtype_q == CH_5) begin
      resp = TX_LOGOUT;
    end
  end

  always_comb begin
    state_d     = state_q;
    pstate_d    = pstate_q;
    tag_d       = tag_q;
    msgtype_d   = msgtype_q;
    hb_rx_d     = hb_rx_q;
    fmt_err_d   = fmt_err_q;
    val_first_d = val_first_q;
    cfg_hb_d    = cfg_hb_q;
    idx_d       = idx_q;
    hb_tx_d     = hb_tx_q;
    logged_on_d = logged_on_q;
    hb_int_d    = hb_int_q;

    if (configure && !tx_active)
      cfg_hb_d = heartBeatInt;

    case (state_q)
      IDLE, RX: begin
        if (enable) begin
          state_d = RX;
          if (din == CH_SEMI) begin
            tag_d    = '0;
            pstate_d = P_TAG;
            if (tag_q == 10'd10) begin
              state_d   = resp;
              idx_d     = '0;
              hb_tx_d   = hb_rx_q;
              msgtype_d = '0;
              hb_rx_d   = '0;
              fmt_err_d = 1'b0;
            end
          end else if (pstate_q == P_TAG) begin
            if (is_digit)
              tag_d = (tag_mac > 14'd999) ? 10'd999 : tag_mac[9:0];
            else if (din == CH_EQ) begin
              pstate_d    = P_VAL;
              val_first_d = 1'b1;
            end else
              fmt_err_d = 1'b1;
          end else begin
            val_first_d = 1'b0;
            if (tag_q == 10'd35 && val_first_q)
              msgtype_d = din;
            if (tag_q == 10'd108) begin
              if (is_digit)
                hb_rx_d = (hb_mac > 12'd255) ? 8'd255 : hb_mac[7:0];
              else
                fmt_err_d = 1'b1;
            end
          end
        end
      end
      TX_ACK, TX_REJ, TX_LOGOUT: begin
        if (tx_last) begin
          state_d = IDLE;
          idx_d   = '0;
          if (state_q == TX_ACK) begin
            logged_on_d = 1'b1;
            hb_int_d    = hb_tx_q;
          end else if (state_q == TX_LOGOUT) begin
            logged_on_d = 1'b0;
          end
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign hund = hb_tx_q / 8'd100;
  assign tens = (hb_tx_q / 8'd10) % 8'd10;
  assign ones = hb_tx_q % 8'd10;

  always_comb begin
    dout = '0;
    if (tx_active) begin
      case (idx_q)
        4'd0:    dout = CH_3;
        4'd1:    dout = CH_5;
        4'd2:    dout = CH_EQ;
        4'd3:    dout = (state_q == TX_ACK) ? CH_A : (state_q == TX_REJ) ? CH_3 : CH_5;
        4'd4:    dout = CH_SEMI;
        4'd5:    dout = 8'h31;
        4'd6:    dout = CH_0;
        4'd7:    dout = 8'h38;
        4'd8:    dout = CH_EQ;
        4'd9:    dout = CH_0 + hund;
        4'd10:   dout = CH_0 + tens;
        4'd11:   dout = CH_0 + ones;
        4'd12:   dout = CH_SEMI;
        default: dout = '0;
      endcase
    end
  end

  assign valid     = tx_active;
  assign busy      = tx_active;
  assign logged_on = logged_on_q;
  assign hb_int    = hb_int_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pstate_q    <= P_TAG;
      tag_q       <= '0;
      msgtype_q   <= '0;
      hb_rx_q     <= '0;
      fmt_err_q   <= 1'b0;
      val_first_q <= 1'b0;
      cfg_hb_q    <= 8'd30;
      idx_q       <= '0;
      hb_tx_q     <= '0;
      logged_on_q <= 1'b0;
      hb_int_q    <= '0;
    end else begin
      state_q     <= state_d;
      pstate_q    <= pstate_d;
      tag_q       <= tag_d;
      msgtype_q   <= msgtype_d;
      hb_rx_q     <= hb_rx_d;
      fmt_err_q   <= fmt_err_d;
      val_first_q <= val_first_d;
      cfg_hb_q    <= cfg_hb_d;
      idx_q       <= idx_d;
      hb_tx_q     <= hb_tx_d;
      logged_on_q <= logged_on_d;
      hb_int_q    <= hb_int_d;
    end
  end

endmodule
